// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: three requesters share one APB master port.
// Round-robin arbitration happens only in IDLE. The winner's address bits
// [9:8] select one of three slaves, and an address that selects no slave is
// rejected with an error without starting an APB transfer. Every output is
// registered.
module apb_master_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  req,
  input  logic [2:0]  m_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m2_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m2_wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Pwrite,
  output logic        Penable,
  output logic [2:0]  Pselx,
  input  logic [31:0] Prdata,
  input  logic        Pready,
  input  logic        Pslverr
);

  // The counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic [1:0]       last_grant;

  logic [2:0][31:0] addr_a, wdata_a;
  logic [2:0]       cand;
  logic [1:0]       win;
  logic             win_vld;
  logic [2:0]       win_oh;
  logic [31:0]      win_addr;
  logic [2:0]       win_sel;
  logic             timed_out;

  assign addr_a  = {m2_addr, m1_addr, m0_addr};
  assign wdata_a = {m2_wdata, m1_wdata, m0_wdata};

  // A requester whose done pulse is high right now is still dropping its
  // request, so it must not win again in the same cycle.
  assign cand = req & ~done;

  // Requester index at round-robin distance off (1..3) from base.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return (s >= 3) ? 2'(s - 3) : 2'(s);
  endfunction

  // Round-robin pick: the first candidate after last_grant wins.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    for (int off = 1; off <= 3; off++) begin
      if (!win_vld && cand[rr_idx(last_grant, off)]) begin
        win_vld = 1'b1;
        win     = rr_idx(last_grant, off);
      end
    end
  end

  assign win_oh   = 3'b001 << win;
  assign win_addr = addr_a[win];

  // Slave decode from the winner's address; 2'b11 selects nothing.
  always_comb begin
    win_sel = 3'b000;
    case (win_addr[9:8])
      2'b00:   win_sel = 3'b001;
      2'b01:   win_sel = 3'b010;
      2'b10:   win_sel = 3'b100;
      default: win_sel = 3'b000;
    endcase
  end

  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

  // Transfer FSM. done, err and rdata default to 0, so each one is high for a
  // single cycle only.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      done       <= 3'b000;
      rdata      <= '0;
      err        <= 1'b0;
      Paddr      <= '0;
      Pwdata     <= '0;
      Pwrite     <= 1'b0;
      Penable    <= 1'b0;
      Pselx      <= 3'b000;
      wait_cnt   <= '0;
      last_grant <= 2'd2;
    end else begin
      done  <= 3'b000;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            last_grant <= win;
            if (win_sel != 3'b000) begin
              state   <= SETUP;
              gnt     <= win_oh;
              Pselx   <= win_sel;
              Penable <= 1'b0;
              Paddr   <= win_addr;
              Pwrite  <= m_write[win];
              Pwdata  <= wdata_a[win];
            end else begin
              // An unmapped address gets an immediate error and no APB cycle.
              done <= win_oh;
              err  <= 1'b1;
            end
          end
        end
        SETUP: begin
          state    <= ACCESS;
          Penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          // If Pready is high in the same cycle the timeout hits, the
          // transfer completes normally.
          if (Pready || timed_out) begin
            state   <= IDLE;
            Pselx   <= 3'b000;
            Penable <= 1'b0;
            gnt     <= 3'b000;
            done    <= gnt;
            err     <= Pready ? Pslverr : 1'b1;
            rdata   <= (Pready && !Pwrite) ? Prdata : '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter. The stimulus pushes the expected
// grant/APB setup values and the expected done responses. A monitor checks
// them when gnt rises, when Penable rises and when done pulses.
module tb_apb_master_arbiter;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  req, m_write;
  logic [31:0] m0_addr, m1_addr, m2_addr, m0_wdata, m1_wdata, m2_wdata;
  logic [2:0]  gnt, done, Pselx;
  logic [31:0] rdata, Paddr, Pwdata, Prdata;
  logic        err, Pwrite, Penable, Pready, Pslverr;

  apb_master_arbiter #(.TIMEOUT(16)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .req(req), .m_write(m_write),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m2_addr(m2_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m2_wdata(m2_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Penable(Penable),
    .Pselx(Pselx), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [2:0]  g;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    bit          gap;   // grant must follow the previous done by one cycle
  } apb_t;

  typedef struct {
    logic [2:0]  d;
    logic        e;
    logic [31:0] rd;
    int          lat;   // cycles from grant to done, -1 = not checked
  } dn_t;

  apb_t apb_q[$];
  dn_t  dn_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int wait_cyc = 0;
  int acc_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge Hclk);
    cyc++;
  end

  // APB slave: holds Pready low for wait_cyc ACCESS cycles, then raises it.
  initial forever begin
    @(negedge Hclk);
    if (Penable) begin
      Pready = (acc_cnt >= wait_cyc);
      acc_cnt++;
    end else begin
      Pready  = 1'b0;
      acc_cnt = 0;
    end
  end

  // Monitor and scoreboard.
  logic [2:0] pg;
  logic       pe;
  int         gcyc, dcyc;
  apb_t       cur;
  dn_t        de;
  initial begin
    pg = 3'b000; pe = 1'b0; gcyc = 0; dcyc = -100;
    cur = '{3'b000, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0};
    forever begin
      @(negedge Hclk);
      if (gnt != 3'b000 && pg == 3'b000) begin
        if (apb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected grant: got gnt=%b expected none", gnt);
        end else begin
          cur = apb_q.pop_front();
          chk("grant", 32'(gnt), 32'(cur.g));
          chk("setup Pselx", 32'(Pselx), 32'(cur.sel));
          chk("setup Paddr", Paddr, cur.addr);
          chk("setup Pwrite", 32'(Pwrite), 32'(cur.wr));
          chk("setup Pwdata", Pwdata, cur.wdata);
          chk("setup Penable", 32'(Penable), 32'd0);
          if (cur.gap) chk("idle gap", 32'(cyc - dcyc), 32'd1);
        end
        gcyc = cyc;
      end
      if (Penable && !pe) begin
        chk("access Pselx", 32'(Pselx), 32'(cur.sel));
        chk("access Paddr", Paddr, cur.addr);
        chk("access Pwdata", Pwdata, cur.wdata);
      end
      if (done != 3'b000) begin
        if (dn_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected done: got done=%b expected none", done);
        end else begin
          de = dn_q.pop_front();
          chk("done", 32'(done), 32'(de.d));
          chk("err", 32'(err), 32'(de.e));
          chk("rdata", rdata, de.rd);
          if (de.lat >= 0) chk("latency", 32'(cyc - gcyc), 32'(de.lat));
        end
        dcyc = cyc;
      end
      pg = gnt;
      pe = Penable;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " gnt"}, 32'(gnt), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " Pselx"}, 32'(Pselx), 32'd0);
    chk({tag, " Penable"}, 32'(Penable), 32'd0);
    chk({tag, " Pwrite"}, 32'(Pwrite), 32'd0);
    chk({tag, " Paddr"}, Paddr, 32'd0);
    chk({tag, " Pwdata"}, Pwdata, 32'd0);
    chk({tag, " rdata"}, rdata, 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
  endtask

  // Drops each requester's req when its done is seen; bounded.
  task automatic serve(input logic [2:0] m, input int budget);
    logic [2:0] pend;
    pend = m;
    for (int k = 0; k < budget && pend != 3'b000; k++) begin
      @(negedge Hclk);
      if ((done & pend) != 3'b000) begin
        req  = req & ~done;
        pend = pend & ~done;
      end
    end
    chk("serve pending", 32'(pend), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Hclk);
    Hreset = 1'b1;
    req    = 3'b000;
    @(negedge Hclk);
    @(negedge Hclk);
    Hreset = 1'b0;
  endtask

  initial begin
    Hreset = 1'b1; req = 3'b000; m_write = 3'b000;
    m0_addr = '0; m1_addr = '0; m2_addr = '0;
    m0_wdata = '0; m1_wdata = '0; m2_wdata = '0;
    Prdata = '0; Pslverr = 1'b0; Pready = 1'b0;
    repeat (3) @(posedge Hclk);
    #1 chk_zero("reset");
    @(negedge Hclk);
    Hreset = 1'b0;

    // Single write to slave 1.
    @(negedge Hclk);
    m_write = 3'b001; m0_addr = 32'h104; m0_wdata = 32'hA5A5A5A5; wait_cyc = 0;
    apb_q.push_back(apb_t'{3'b001, 3'b010, 32'h104, 1'b1, 32'hA5A5A5A5, 1'b0});
    dn_q.push_back(dn_t'{3'b001, 1'b0, 32'h0, 2});
    req = 3'b001;
    serve(3'b001, 50);

    // All three requesters after reset: order 0,1,2 with one IDLE cycle between.
    do_reset();
    m_write = 3'b111;
    m0_addr = 32'h000; m1_addr = 32'h100; m2_addr = 32'h200;
    m0_wdata = 32'hAAAA0000; m1_wdata = 32'hBBBB1111; m2_wdata = 32'hCCCC2222;
    apb_q.push_back(apb_t'{3'b001, 3'b001, 32'h000, 1'b1, 32'hAAAA0000, 1'b0});
    apb_q.push_back(apb_t'{3'b010, 3'b010, 32'h100, 1'b1, 32'hBBBB1111, 1'b1});
    apb_q.push_back(apb_t'{3'b100, 3'b100, 32'h200, 1'b1, 32'hCCCC2222, 1'b1});
    dn_q.push_back(dn_t'{3'b001, 1'b0, 32'h0, 2});
    dn_q.push_back(dn_t'{3'b010, 1'b0, 32'h0, 2});
    dn_q.push_back(dn_t'{3'b100, 1'b0, 32'h0, 2});
    req = 3'b111;
    serve(3'b111, 60);

    // Read with three wait states.
    @(negedge Hclk);
    m_write = 3'b000; m1_addr = 32'h000; m1_wdata = 32'h0BAD0001;
    Prdata = 32'h12345678; wait_cyc = 3;
    apb_q.push_back(apb_t'{3'b010, 3'b001, 32'h000, 1'b0, 32'h0BAD0001, 1'b0});
    dn_q.push_back(dn_t'{3'b010, 1'b0, 32'h12345678, 5});
    req = 3'b010;
    serve(3'b010, 50);

    // Write with slave error; req is dropped right after the grant.
    @(negedge Hclk);
    m_write = 3'b001; m0_addr = 32'h200; m0_wdata = 32'h5555AAAA;
    Prdata = 32'hFFFF0000; Pslverr = 1'b1; wait_cyc = 1;
    apb_q.push_back(apb_t'{3'b001, 3'b100, 32'h200, 1'b1, 32'h5555AAAA, 1'b0});
    dn_q.push_back(dn_t'{3'b001, 1'b1, 32'h0, 3});
    req = 3'b001;
    for (int k = 0; k < 10 && gnt[0] != 1'b1; k++) @(negedge Hclk);
    req = 3'b000;
    serve(3'b001, 50);

    // Read with slave error still returns Prdata.
    @(negedge Hclk);
    m_write = 3'b000; m2_addr = 32'h1FC; m2_wdata = 32'h22222222;
    Prdata = 32'hCAFEF00D; Pslverr = 1'b1; wait_cyc = 0;
    apb_q.push_back(apb_t'{3'b100, 3'b010, 32'h1FC, 1'b0, 32'h22222222, 1'b0});
    dn_q.push_back(dn_t'{3'b100, 1'b1, 32'hCAFEF00D, 2});
    req = 3'b100;
    serve(3'b100, 50);

    // Timeout: Pready never rises.
    @(negedge Hclk);
    m_write = 3'b000; m0_addr = 32'h004; m0_wdata = 32'h33333333;
    Prdata = 32'hFFFFFFFF; Pslverr = 1'b0; wait_cyc = 1000;
    apb_q.push_back(apb_t'{3'b001, 3'b001, 32'h004, 1'b0, 32'h33333333, 1'b0});
    dn_q.push_back(dn_t'{3'b001, 1'b1, 32'h0, 17});
    req = 3'b001;
    serve(3'b001, 60);

    // Pready rises on the cycle the timeout would fire: normal completion.
    @(negedge Hclk);
    m0_addr = 32'h008; Prdata = 32'h87654321; wait_cyc = 15;
    apb_q.push_back(apb_t'{3'b001, 3'b001, 32'h008, 1'b0, 32'h33333333, 1'b0});
    dn_q.push_back(dn_t'{3'b001, 1'b0, 32'h87654321, 17});
    req = 3'b001;
    serve(3'b001, 60);

    // Unmapped address: error one edge after arbitration, no slave select.
    @(negedge Hclk);
    m_write = 3'b100; m2_addr = 32'h300; wait_cyc = 0;
    dn_q.push_back(dn_t'{3'b100, 1'b1, 32'h0, -1});
    req = 3'b100;
    @(posedge Hclk);
    #1;
    chk("illegal done", 32'(done), 32'b100);
    chk("illegal err", 32'(err), 32'd1);
    chk("illegal Pselx", 32'(Pselx), 32'd0);
    chk("illegal gnt", 32'(gnt), 32'd0);
    serve(3'b100, 10);

    // Reset during ACCESS: outputs clear and there is no done pulse.
    @(negedge Hclk);
    m_write = 3'b001; m0_addr = 32'h010; m0_wdata = 32'h44444444;
    Pslverr = 1'b0; wait_cyc = 1000;
    apb_q.push_back(apb_t'{3'b001, 3'b001, 32'h010, 1'b1, 32'h44444444, 1'b0});
    req = 3'b001;
    for (int k = 0; k < 10 && Penable != 1'b1; k++) @(negedge Hclk);
    chk("reached access", 32'(Penable), 32'd1);
    repeat (3) @(negedge Hclk);
    Hreset = 1'b1;
    @(posedge Hclk);
    #1 chk_zero("mid reset");
    @(negedge Hclk);
    Hreset = 1'b0; wait_cyc = 0;
    m_write = 3'b011; m1_addr = 32'h100; m1_wdata = 32'h66666666;
    apb_q.push_back(apb_t'{3'b001, 3'b001, 32'h010, 1'b1, 32'h44444444, 1'b0});
    apb_q.push_back(apb_t'{3'b010, 3'b010, 32'h100, 1'b1, 32'h66666666, 1'b1});
    dn_q.push_back(dn_t'{3'b001, 1'b0, 32'h0, 2});
    dn_q.push_back(dn_t'{3'b010, 1'b0, 32'h0, 2});
    req = 3'b011;
    serve(3'b011, 60);

    repeat (5) @(negedge Hclk);
    chk("apb queue drained", 32'(apb_q.size()), 32'd0);
    chk("done queue drained", 32'(dn_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
